// File: rtl/anc_mc_sched_pkg.sv
// Shared types and defaults for the multi-channel ANC scheduler.
// Holds the job FSM encoding and the round-robin pointer helper.
package anc_pkg;

   localparam int DATA_W      = 16;
   localparam int TMO_CYC_DEF = 1024;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_EMIT
   } state_t;

   function automatic int next_ch(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/anc_mc_sched_arb.sv
// Combinational NCH-way round-robin arbiter: the first requester at or after
// ptr wins; returns a one-hot grant, its index and an any-request flag.
module anc_rr_arb #(
   parameter int NCH = 4,
   parameter int CW  = $clog2(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [CW-1:0]  ptr,
   output logic [NCH-1:0] gnt,
   output logic [CW-1:0]  idx,
   output logic           any
);

   logic [CW-1:0] cand;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = 0; i < NCH; i++) begin
         cand = CW'((int'(ptr) + i) % NCH);
         if (!any && req[cand]) begin
            gnt[cand] = 1'b1;
            idx       = cand;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/anc_mc_sched.sv
// Time-shares one LMS FIR engine across NCH ANC channels: buffers one sample
// set per channel, issues round-robin jobs, returns channel-tagged results.
module anc_mc_sched
   import anc_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int W       = DATA_W,
   parameter int TMO_CYC = TMO_CYC_DEF,
   parameter int CW      = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init_done,
   input  logic [NCH-1:0]   ch_valid,
   output logic [NCH-1:0]   ch_ready,
   input  logic [NCH*W-1:0] ch_e,
   input  logic [NCH*W-1:0] ch_x,
   input  logic [NCH*W-1:0] ch_a,
   input  logic [NCH*W-1:0] ch_u,
   input  logic [NCH-1:0]   bypass_sel,
   output logic             eng_go,
   output logic [CW-1:0]    eng_ch,
   output logic [W-1:0]     eng_e,
   output logic [W-1:0]     eng_x,
   output logic [W-1:0]     eng_a,
   output logic [W-1:0]     eng_u,
   input  logic             eng_done,
   input  logic [W-1:0]     eng_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_ch,
   output logic [W-1:0]     out_sample,
   output logic             out_err,
   input  logic             clr_status,
   output logic [NCH-1:0]   ovr_flag,
   output logic             tmo_flag
);

   localparam int TW = $clog2(TMO_CYC);

   state_t         state, state_nxt;
   logic [NCH-1:0] pend;
   logic [NCH-1:0] acc;
   logic [W-1:0]   e_q [NCH];
   logic [W-1:0]   x_q [NCH];
   logic [W-1:0]   a_q [NCH];
   logic [W-1:0]   u_q [NCH];
   logic [CW-1:0]  rr_ptr;
   logic [NCH-1:0] arb_gnt;
   logic [CW-1:0]  arb_idx;
   logic           arb_any;
   logic [TW-1:0]  tmo_cnt;
   logic           grant_en, done_hit, tmo_hit;

   assign ch_ready = {NCH{init_done}} & ~pend;
   assign acc      = ch_valid & ch_ready;
   assign out_ch   = eng_ch;

   anc_rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
      .req (pend),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_comb begin
      state_nxt = state;
      grant_en  = 1'b0;
      done_hit  = 1'b0;
      tmo_hit   = 1'b0;
      eng_go    = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: if (init_done && arb_any) begin
            grant_en  = 1'b1;
            state_nxt = bypass_sel[arb_idx] ? S_EMIT : S_ISSUE;
         end
         S_ISSUE: begin
            eng_go    = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A done arriving on the timeout cycle still delivers the real result.
            if (eng_done) begin
               done_hit  = 1'b1;
               state_nxt = S_EMIT;
            end else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
               tmo_hit   = 1'b1;
               state_nxt = S_EMIT;
            end
         end
         S_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend       <= '0;
         rr_ptr     <= '0;
         eng_ch     <= '0;
         eng_e      <= '0;
         eng_x      <= '0;
         eng_a      <= '0;
         eng_u      <= '0;
         out_sample <= '0;
         out_err    <= 1'b0;
         tmo_cnt    <= '0;
         ovr_flag   <= '0;
         tmo_flag   <= 1'b0;
         // NOTE: the per-channel sample buffers are small registers, so they are reset too.
         for (int c = 0; c < NCH; c++) begin
            e_q[c] <= '0;
            x_q[c] <= '0;
            a_q[c] <= '0;
            u_q[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (acc[c]) begin
               e_q[c] <= ch_e[c*W +: W];
               x_q[c] <= ch_x[c*W +: W];
               a_q[c] <= ch_a[c*W +: W];
               u_q[c] <= ch_u[c*W +: W];
            end
         end
         pend <= (pend | acc) & ~(grant_en ? arb_gnt : '0);

         if (grant_en) begin
            eng_ch <= arb_idx;
            eng_e  <= e_q[arb_idx];
            eng_x  <= x_q[arb_idx];
            eng_a  <= a_q[arb_idx];
            eng_u  <= u_q[arb_idx];
            rr_ptr <= CW'(next_ch(int'(arb_idx), NCH));
            if (bypass_sel[arb_idx]) begin
               out_sample <= x_q[arb_idx];
               out_err    <= 1'b0;
            end
         end

         if (state == S_ISSUE)     tmo_cnt <= '0;
         else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;

         if (done_hit) begin
            out_sample <= eng_out;
            out_err    <= 1'b0;
         end else if (tmo_hit) begin
            out_sample <= eng_x;
            out_err    <= 1'b1;
         end

         // New events override a simultaneous clear.
         ovr_flag <= (ovr_flag & ~{NCH{clr_status}}) | (ch_valid & ~ch_ready);
         tmo_flag <= (tmo_flag & ~clr_status) | tmo_hit;
      end
   end

endmodule

// File: tb/tb_anc_mc_sched.sv
// Directed bench for anc_mc_sched: inputs change and outputs are sampled on
// the falling clock edge; each task checks one scenario inline.
module tb_anc_mc_sched;

   localparam int NCH = 4;
   localparam int W   = 16;
   localparam int TMO = 1024;
   localparam int CW  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             init_done;
   logic [NCH-1:0]   ch_valid;
   logic [NCH-1:0]   ch_ready;
   logic [NCH*W-1:0] ch_e, ch_x, ch_a, ch_u;
   logic [NCH-1:0]   bypass_sel;
   logic             eng_go;
   logic [CW-1:0]    eng_ch;
   logic [W-1:0]     eng_e, eng_x, eng_a, eng_u;
   logic             eng_done;
   logic [W-1:0]     eng_out;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    out_ch;
   logic [W-1:0]     out_sample;
   logic             out_err;
   logic             clr_status;
   logic [NCH-1:0]   ovr_flag;
   logic             tmo_flag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   anc_mc_sched #(.NCH(NCH), .W(W), .TMO_CYC(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .init_done  (init_done),
      .ch_valid   (ch_valid),
      .ch_ready   (ch_ready),
      .ch_e       (ch_e),
      .ch_x       (ch_x),
      .ch_a       (ch_a),
      .ch_u       (ch_u),
      .bypass_sel (bypass_sel),
      .eng_go     (eng_go),
      .eng_ch     (eng_ch),
      .eng_e      (eng_e),
      .eng_x      (eng_x),
      .eng_a      (eng_a),
      .eng_u      (eng_u),
      .eng_done   (eng_done),
      .eng_out    (eng_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ch     (out_ch),
      .out_sample (out_sample),
      .out_err    (out_err),
      .clr_status (clr_status),
      .ovr_flag   (ovr_flag),
      .tmo_flag   (tmo_flag)
   );

   task automatic set_ch(input int c, input logic [W-1:0] e, input logic [W-1:0] x,
                         input logic [W-1:0] a, input logic [W-1:0] u);
      ch_e[c*W +: W] = e;
      ch_x[c*W +: W] = x;
      ch_a[c*W +: W] = a;
      ch_u[c*W +: W] = u;
   endtask

   task automatic wait_go(input int bound, output bit got);
      got = 1'b0;
      for (int i = 0; i < bound; i++) begin
         if (eng_go) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      init_done = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({out_valid, eng_go, out_err, tmo_flag} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 0000", {out_valid, eng_go, out_err, tmo_flag});
      end
      checks++;
      if ({eng_ch, eng_x, out_sample, ovr_flag} !== '0) begin
         errors++;
         $display("FAIL reset_data got ch=%0d x=%h s=%h ovr=%b want zeros", eng_ch, eng_x, out_sample, ovr_flag);
      end
      checks++;
      if (ch_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready_noinit got %b want 0000", ch_ready);
      end
      rst = 1'b0;
      init_done = 1'b1;
      @(negedge clk);
      checks++;
      if (ch_ready !== 4'b1111) begin
         errors++;
         $display("FAIL ready_after_init got %b want 1111", ch_ready);
      end
   endtask

   task automatic test_single();
      bit got;
      set_ch(1, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
      ch_valid = 4'b0010;
      @(negedge clk);
      ch_valid = '0;
      checks++;
      if ({ch_ready[1], eng_go} !== 2'b00) begin
         errors++;
         $display("FAIL single_t1 got ready1/go=%b want 00", {ch_ready[1], eng_go});
      end
      @(negedge clk);
      checks++;
      if ({eng_go, eng_ch, eng_e, eng_x, eng_a, eng_u} !== {1'b1, 2'd1, 16'h0011, 16'h0022, 16'h0033, 16'h0044}) begin
         errors++;
         $display("FAIL single_issue got go=%b ch=%0d e=%h x=%h a=%h u=%h want 1/1/0011/0022/0033/0044",
                  eng_go, eng_ch, eng_e, eng_x, eng_a, eng_u);
      end
      got = 1'b0;
      for (int i = 0; i < 299; i++) begin
         @(negedge clk);
         if (eng_go || out_valid) got = 1'b1;
      end
      checks++;
      if (got !== 1'b0) begin
         errors++;
         $display("FAIL single_wait_quiet got extra go/valid=1 want 0");
      end
      eng_done = 1'b1;
      eng_out  = 16'h1234;
      @(negedge clk);
      eng_done = 1'b0;
      checks++;
      if ({out_valid, out_ch, out_sample, out_err} !== {1'b1, 2'd1, 16'h1234, 1'b0}) begin
         errors++;
         $display("FAIL single_result got v=%b ch=%0d s=%h err=%b want 1/1/1234/0",
                  out_valid, out_ch, out_sample, out_err);
      end
      pop();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_pop got valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_rr_order();
      bit got;
      logic [CW-1:0] exp_ch [5];
      logic [W-1:0]  exp_x  [5];
      exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      exp_x  = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 16'h00F0};
      pulse_rst();
      for (int c = 0; c < NCH; c++) set_ch(c, 16'h0100, 16'h0A00 + 16'(c), 16'h0200, 16'h0300);
      ch_valid = 4'b1111;
      @(negedge clk);
      ch_valid = '0;
      for (int k = 0; k < 5; k++) begin
         wait_go(20, got);
         checks++;
         if ({got, eng_ch, eng_x} !== {1'b1, exp_ch[k], exp_x[k]}) begin
            errors++;
            $display("FAIL rr_grant%0d got go=%b ch=%0d x=%h want 1/%0d/%h", k, got, eng_ch, eng_x, exp_ch[k], exp_x[k]);
         end
         if (k == 0) begin
            set_ch(0, 16'h0100, 16'h00F0, 16'h0200, 16'h0300);
            ch_valid = 4'b0001;
         end
         @(negedge clk);
         ch_valid = '0;
         eng_done = 1'b1;
         eng_out  = 16'h0100 + 16'(k);
         @(negedge clk);
         eng_done = 1'b0;
         checks++;
         if ({out_valid, out_ch, out_sample} !== {1'b1, exp_ch[k], 16'h0100 + 16'(k)}) begin
            errors++;
            $display("FAIL rr_result%0d got v=%b ch=%0d s=%h want 1/%0d/%h", k, out_valid, out_ch, out_sample,
                     exp_ch[k], 16'h0100 + 16'(k));
         end
         pop();
      end
   endtask

   task automatic test_bypass();
      set_ch(2, 16'h1111, 16'h8001, 16'h2222, 16'h3333);
      bypass_sel = 4'b0100;
      ch_valid   = 4'b0100;
      @(negedge clk);
      ch_valid = '0;
      checks++;
      if (eng_go !== 1'b0) begin
         errors++;
         $display("FAIL bypass_t1 got go=%b want 0", eng_go);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, out_ch, out_sample, out_err, eng_go} !== {1'b1, 2'd2, 16'h8001, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL bypass_result got v=%b ch=%0d s=%h err=%b go=%b want 1/2/8001/0/0",
                  out_valid, out_ch, out_sample, out_err, eng_go);
      end
      pop();
      bypass_sel = '0;
   endtask

   task automatic test_timeout();
      bit got;
      int n;
      set_ch(3, 16'h0001, 16'h5A5A, 16'h0002, 16'h0003);
      ch_valid = 4'b1000;
      @(negedge clk);
      ch_valid = '0;
      wait_go(10, got);
      n = 0;
      for (int i = 0; i < TMO + 20; i++) begin
         @(negedge clk);
         n++;
         if (out_valid) break;
      end
      checks++;
      if ({got, out_valid} !== 2'b11 || n < TMO - 1 || n > TMO + 2) begin
         errors++;
         $display("FAIL tmo_latency got go=%b valid=%b after %0d cycles want 1/1 near %0d", got, out_valid, n, TMO);
      end
      checks++;
      if ({out_err, out_sample, out_ch, tmo_flag} !== {1'b1, 16'h5A5A, 2'd3, 1'b1}) begin
         errors++;
         $display("FAIL tmo_result got err=%b s=%h ch=%0d flag=%b want 1/5a5a/3/1", out_err, out_sample, out_ch, tmo_flag);
      end
      pop();
      checks++;
      if (tmo_flag !== 1'b1) begin
         errors++;
         $display("FAIL tmo_sticky got %b want 1", tmo_flag);
      end
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      checks++;
      if (tmo_flag !== 1'b0) begin
         errors++;
         $display("FAIL tmo_clear got %b want 0", tmo_flag);
      end
   endtask

   task automatic test_overrun_stall();
      bit got;
      bit stall_bad;
      set_ch(0, 16'h0001, 16'h0A0A, 16'h0002, 16'h0003);
      ch_valid = 4'b0001;
      @(negedge clk);
      set_ch(0, 16'h0009, 16'h0B0B, 16'h0009, 16'h0009);
      @(negedge clk);
      ch_valid = '0;
      checks++;
      if ({eng_go, eng_ch, eng_x, ovr_flag} !== {1'b1, 2'd0, 16'h0A0A, 4'b0001}) begin
         errors++;
         $display("FAIL ovr_drop got go=%b ch=%0d x=%h ovr=%b want 1/0/0a0a/0001", eng_go, eng_ch, eng_x, ovr_flag);
      end
      @(negedge clk);
      eng_done = 1'b1;
      eng_out  = 16'h7777;
      @(negedge clk);
      eng_done = 1'b0;
      set_ch(1, 16'h0004, 16'h1111, 16'h0005, 16'h0006);
      ch_valid = 4'b0010;
      @(negedge clk);
      ch_valid  = '0;
      stall_bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (eng_go || !out_valid || out_ch !== 2'd0 || out_sample !== 16'h7777 || out_err) stall_bad = 1'b1;
         ch_valid   = (i == 10) ? 4'b0010 : 4'b0000;
         clr_status = (i == 10);
         @(negedge clk);
      end
      ch_valid   = '0;
      clr_status = 1'b0;
      checks++;
      if (stall_bad !== 1'b0) begin
         errors++;
         $display("FAIL stall_stable got disturbance=%b want 0", stall_bad);
      end
      checks++;
      if (ovr_flag !== 4'b0010) begin
         errors++;
         $display("FAIL ovr_clr_vs_event got %b want 0010", ovr_flag);
      end
      pop();
      wait_go(10, got);
      checks++;
      if ({got, eng_ch, eng_x} !== {1'b1, 2'd1, 16'h1111}) begin
         errors++;
         $display("FAIL stall_next_job got go=%b ch=%0d x=%h want 1/1/1111", got, eng_ch, eng_x);
      end
      @(negedge clk);
      eng_done = 1'b1;
      eng_out  = 16'h2222;
      @(negedge clk);
      eng_done = 1'b0;
      pop();
      clr_status = 1'b1;
      @(negedge clk);
      clr_status = 1'b0;
      checks++;
      if (ovr_flag !== 4'b0000) begin
         errors++;
         $display("FAIL ovr_clear got %b want 0000", ovr_flag);
      end
   endtask

   task automatic test_rst_mid();
      bit got;
      bit quiet_bad;
      set_ch(2, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
      ch_valid = 4'b0100;
      @(negedge clk);
      ch_valid = '0;
      wait_go(10, got);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({got, out_valid, eng_go, eng_ch, eng_x, out_sample} !== {1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000}) begin
         errors++;
         $display("FAIL rst_mid got go_seen=%b v=%b go=%b ch=%0d x=%h s=%h want 1/0/0/0/0000/0000",
                  got, out_valid, eng_go, eng_ch, eng_x, out_sample);
      end
      eng_done = 1'b1;
      eng_out  = 16'hDEAD;
      @(negedge clk);
      eng_done  = 1'b0;
      quiet_bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid || eng_go) quiet_bad = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (quiet_bad !== 1'b0) begin
         errors++;
         $display("FAIL late_done_ignored got activity=%b want 0", quiet_bad);
      end
      init_done = 1'b0;
      @(negedge clk);
      checks++;
      if (ch_ready !== 4'b0000) begin
         errors++;
         $display("FAIL noinit_ready got %b want 0000", ch_ready);
      end
   endtask

   initial begin
      rst        = 1'b1;
      init_done  = 1'b0;
      ch_valid   = '0;
      ch_e       = '0;
      ch_x       = '0;
      ch_a       = '0;
      ch_u       = '0;
      bypass_sel = '0;
      eng_done   = 1'b0;
      eng_out    = '0;
      out_ready  = 1'b0;
      clr_status = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_rr_order();
      test_bypass();
      test_timeout();
      test_overrun_stall();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
